// File: rtl/morph_window_3x3.sv
// 3x3 greyscale dilate/erode window with cross or square element and edge replication.
// Optional MORPH_BINARIZE_EN: thresholds each channel against THRESH in the output register.
module morph_window_3x3 #(
    parameter int CH_W      = 8,
    parameter int CHANNELS  = 3,
    parameter int PIC_WIDTH = 480,
    parameter int THRESH    = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic                     mode_in,
    input  logic                     se_sq_in,
    input  logic [CHANNELS*CH_W-1:0] din1,
    input  logic [CHANNELS*CH_W-1:0] din2,
    input  logic [CHANNELS*CH_W-1:0] din3,
    output logic [CHANNELS*CH_W-1:0] dout,
    output logic                     valid_out,
    output logic                     eol_out
);

    localparam int W     = CHANNELS * CH_W;
    localparam int COL_W = $clog2(PIC_WIDTH);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(PIC_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    logic [2:0][W-1:0] prev_q, prev_d;
    logic [2:0][W-1:0] cur_q, cur_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              flush_q, flush_d;
    logic              mode_q, mode_d;
    logic              se_sq_q, se_sq_d;
    logic [W-1:0]      dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              eol_q, eol_d;

    logic [2:0][W-1:0] din_w;
    logic [2:0][W-1:0] lt, ct, rt;
    logic [W-1:0]      res;
    logic              emit;
    logic              left_rep;

    // Taps ordered row-major: 0..2 row above, 3..5 centre, 6..8 row below.
    function automatic logic [CH_W-1:0] win_op(
        input logic [8:0][CH_W-1:0] t,
        input logic                 ero,
        input logic                 sq
    );
        logic [CH_W-1:0] r;
        logic            use_t;
        r = t[4];
        for (int i = 0; i < 9; i++) begin
            use_t = sq || (i == 1) || (i == 3) || (i == 5) || (i == 7);
            if (use_t) begin
                if (ero) begin
                    if (t[i] < r) r = t[i];
                end else begin
                    if (t[i] > r) r = t[i];
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        din_w    = {din3, din2, din1};
        emit     = flush_q || (valid_in && (col_q != '0));
        left_rep = !flush_q && (col_q == COL_ONE);
        for (int r = 0; r < 3; r++) begin
            lt[r] = left_rep ? cur_q[r] : prev_q[r];
            ct[r] = cur_q[r];
            rt[r] = flush_q ? cur_q[r] : din_w[r];
        end
    end

    always_comb begin
        logic [8:0][CH_W-1:0] taps;
        logic [CH_W-1:0]      v;
        res  = '0;
        taps = '0;
        v    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            for (int r = 0; r < 3; r++) begin
                taps[3*r]     = lt[r][k*CH_W +: CH_W];
                taps[3*r + 1] = ct[r][k*CH_W +: CH_W];
                taps[3*r + 2] = rt[r][k*CH_W +: CH_W];
            end
            v = win_op(taps, mode_q, se_sq_q);
`ifdef MORPH_BINARIZE_EN
            res[k*CH_W +: CH_W] = (v >= CH_W'(THRESH)) ? '1 : '0;
`else
            res[k*CH_W +: CH_W] = v;
`endif
        end
    end

    always_comb begin
        prev_d  = prev_q;
        cur_d   = cur_q;
        col_d   = col_q;
        flush_d = flush_q;
        mode_d  = mode_q;
        se_sq_d = se_sq_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        eol_d   = 1'b0;

        // The window reads the taps before they shift, so flush and
        // the next row's column 0 can share an edge.
        if (emit) begin
            dout_d  = res;
            valid_d = 1'b1;
            eol_d   = flush_q;
            flush_d = 1'b0;
        end

        if (valid_in) begin
            prev_d = cur_q;
            cur_d  = din_w;
            if (col_q == '0) begin
                mode_d  = mode_in;
                se_sq_d = se_sq_in;
            end
            if (col_q == LAST_COL) begin
                col_d   = '0;
                flush_d = 1'b1;
            end else begin
                col_d = col_q + COL_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= '0;
            cur_q   <= '0;
            col_q   <= '0;
            flush_q <= 1'b0;
            mode_q  <= 1'b0;
            se_sq_q <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            col_q   <= col_d;
            flush_q <= flush_d;
            mode_q  <= mode_d;
            se_sq_q <= se_sq_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            eol_q   <= eol_d;
        end
    end

    assign dout      = dout_q;
    assign valid_out = valid_q;
    assign eol_out   = eol_q;

endmodule

// File: tb/tb_morph_window_3x3.sv
// Directed and randomized bench for morph_window_3x3 against a row-buffer model.
module tb_morph_window_3x3;

    localparam int CH_W = 8;
    localparam int CH   = 3;
    localparam int PW   = 4;
    localparam int W    = CH * CH_W;
    localparam int THR  = 128;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_in = 1'b0;
    logic         mode_in = 1'b0;
    logic         se_sq_in = 1'b0;
    logic [W-1:0] din1 = '0;
    logic [W-1:0] din2 = '0;
    logic [W-1:0] din3 = '0;
    logic [W-1:0] dout;
    logic         valid_out;
    logic         eol_out;

    morph_window_3x3 #(
        .CH_W(CH_W), .CHANNELS(CH), .PIC_WIDTH(PW), .THRESH(THR)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .mode_in(mode_in), .se_sq_in(se_sq_in),
        .din1(din1), .din2(din2), .din3(din3),
        .dout(dout), .valid_out(valid_out), .eol_out(eol_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int pulses = 0;

    // Model state: the pixels of the current row, kept whole.
    logic [W-1:0] rb[3][PW];
    logic [W-1:0] in1[PW], in2[PW], in3[PW];
    int           bcol = 0;
    bit           bflush = 0, bmode = 0, bsq = 0;
    logic [W-1:0] last_dout = '0;
    logic [W-1:0] got_q[$];
    logic [W-1:0] ref_q[$];

    task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] model_f(int l, int c, int r, bit ero, bit sq);
        logic [W-1:0] o = '0;
        for (int k = 0; k < CH; k++) begin
            int vals[$];
            int m;
            vals.push_back(int'(rb[0][c][k*CH_W +: CH_W]));
            vals.push_back(int'(rb[1][l][k*CH_W +: CH_W]));
            vals.push_back(int'(rb[1][c][k*CH_W +: CH_W]));
            vals.push_back(int'(rb[1][r][k*CH_W +: CH_W]));
            vals.push_back(int'(rb[2][c][k*CH_W +: CH_W]));
            if (sq) begin
                vals.push_back(int'(rb[0][l][k*CH_W +: CH_W]));
                vals.push_back(int'(rb[0][r][k*CH_W +: CH_W]));
                vals.push_back(int'(rb[2][l][k*CH_W +: CH_W]));
                vals.push_back(int'(rb[2][r][k*CH_W +: CH_W]));
            end
            m = vals[0];
            foreach (vals[i]) m = ero ? ((vals[i] < m) ? vals[i] : m)
                                      : ((vals[i] > m) ? vals[i] : m);
`ifdef MORPH_BINARIZE_EN
            m = (m >= THR) ? 255 : 0;
`endif
            o[k*CH_W +: CH_W] = CH_W'(m);
        end
        return o;
    endfunction

    task automatic step(bit v, bit m, bit s,
                        logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c);
        bit           ev = 0;
        bit           ee = 0;
        logic [W-1:0] ed = last_dout;
        rst = 1'b0;
        valid_in = v; mode_in = m; se_sq_in = s;
        din1 = a; din2 = b; din3 = c;
        if (bflush) begin
            ed = model_f(PW - 2, PW - 1, PW - 1, bmode, bsq);
            ev = 1; ee = 1; bflush = 0;
        end
        if (v) begin
            if (bcol == 0) begin
                bmode = m; bsq = s;
            end
            rb[0][bcol] = a; rb[1][bcol] = b; rb[2][bcol] = c;
            if (bcol > 0) begin
                ed = model_f((bcol == 1) ? 0 : bcol - 2, bcol - 1, bcol, bmode, bsq);
                ev = 1;
            end
            if (bcol == PW - 1) begin
                bflush = 1; bcol = 0;
            end else begin
                bcol++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("valid_out", W'(valid_out), W'(ev));
        chk("eol_out", W'(eol_out), W'(ee));
        chk("dout", dout, ed);
        if (valid_out) begin
            got_q.push_back(dout);
            pulses++;
        end
        last_dout = ed;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", W'(valid_out), '0);
        chk("rst_eol", W'(eol_out), '0);
        chk("rst_dout", dout, '0);
        bcol = 0; bflush = 0; bmode = 0; bsq = 0;
        last_dout = '0;
        rst = 1'b0;
    endtask

    task automatic idle();
        step(0, 1'($urandom), 1'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    // Mode bits presented after column 0 are random and must be ignored.
    task automatic row(bit m, bit s, int gapmax);
        for (int c = 0; c < PW; c++) begin
            int g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            for (int i = 0; i < g; i++) idle();
            if (c == 0) step(1, m, s, in1[c], in2[c], in3[c]);
            else step(1, 1'($urandom), 1'($urandom), in1[c], in2[c], in3[c]);
        end
    endtask

    function automatic logic [W-1:0] rep(int x);
        logic [CH_W-1:0] p = CH_W'(x);
        return {CH{p}};
    endfunction

    task automatic set_plan(int z);
        for (int c = 0; c < PW; c++) begin
            in1[c] = rep(c + 1);
            in2[c] = rep(c + 5);
            in3[c] = rep(c + 9);
        end
        if (z) in2[0] = rep(0);
    endtask

    task automatic chk_seq(string tag, int e0, int e1, int e2, int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk({tag, "_n"}, W'(got_q.size()), W'(PW));
`ifndef MORPH_BINARIZE_EN
        for (int i = 0; i < PW && i < got_q.size(); i++)
            chk(tag, got_q[i], rep(e[i]));
`endif
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        set_plan(0);
        got_q.delete();
        row(0, 1, 0);
        idle();
        chk_seq("sq_dilate", 10, 11, 12, 12);

        got_q.delete();
        row(1, 0, 0);
        idle();
        chk_seq("cr_erode", 1, 2, 3, 4);

        set_plan(1);
        got_q.delete();
        row(1, 0, 0);
        idle();
        chk_seq("cr_erode_lrep", 0, 0, 3, 4);

        for (int c = 0; c < PW; c++) begin
            in1[c] = {8'hFF, 8'(c * 20), 8'h10};
            in2[c] = {8'hFF, 8'(c * 20 + 5), 8'h10};
            in3[c] = {8'hFF, 8'(c * 20 + 9), 8'h10};
        end
        got_q.delete();
        row(0, 1'($urandom), 0);
        idle();
`ifndef MORPH_BINARIZE_EN
        foreach (got_q[i]) begin
            chk("ch0_const", W'(got_q[i][7:0]), W'(8'h10));
            chk("ch2_const", W'(got_q[i][23:16]), W'(8'hFF));
        end
`endif

        for (int t = 0; t < 4; t++) begin
            bit m = 1'($urandom);
            bit s = 1'($urandom);
            for (int c = 0; c < PW; c++) begin
                in1[c] = W'($urandom); in2[c] = W'($urandom); in3[c] = W'($urandom);
            end
            got_q.delete();
            row(m, s, 0);
            idle();
            ref_q = got_q;
            got_q.delete();
            row(m, s, 3);
            idle();
            chk("gap_n", W'(got_q.size()), W'(ref_q.size()));
            foreach (ref_q[i])
                if (i < got_q.size()) chk("gap_same", got_q[i], ref_q[i]);
        end

        pulses = 0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < PW; c++) begin
                in1[c] = W'($urandom); in2[c] = W'($urandom); in3[c] = W'($urandom);
            end
            row(1'(r), 1'(r), 0);
        end
        idle();
        chk("b2b_pulses", W'(pulses), W'(2 * PW));

        step(1, 1, 1, W'($urandom), W'($urandom), W'($urandom));
        step(1, 0, 0, W'($urandom), W'($urandom), W'($urandom));
        do_reset();
        set_plan(0);
        got_q.delete();
        row(0, 1, 0);
        idle();
        idle();
        chk_seq("post_rst", 10, 11, 12, 12);

        for (int t = 0; t < 30; t++) begin
            for (int c = 0; c < PW; c++) begin
                in1[c] = W'($urandom); in2[c] = W'($urandom); in3[c] = W'($urandom);
            end
            row(1'($urandom), 1'($urandom), int'($urandom_range(3, 0)));
            if ($urandom_range(1, 0) == 1) idle();
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/morph_window_3x3.md
Name: morph_window_3x3

Overview:
- Parametrised 3x3 greyscale morphology engine: dilate (max) or erode (min), with cross or square structuring element.
- Supports multiple packed channels and replicates edge pixels at the left and right borders of each row.
- Sits after the line-buffer stage, which supplies three vertically aligned row taps per pixel.
- Feeds the binarisation/output stage with one result per input pixel.

Parameters:
- CH_W, 8: bits per channel.
- CHANNELS, 3: channels packed in each pixel word; channel k occupies bits [k*CH_W +: CH_W].
- PIC_WIDTH, 480: pixels per row; must be >= 3.
- THRESH, 128: binarisation threshold, used only with MORPH_BINARIZE_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- valid_in  in  1  pixel strobe; din1..din3 and mode inputs are sampled on clk when high
- mode_in  in  1  0 = dilate (max), 1 = erode (min)
- se_sq_in  in  1  0 = cross (5 taps), 1 = square (9 taps)
- din1  in  CHANNELS*CH_W  row above
- din2  in  CHANNELS*CH_W  centre row
- din3  in  CHANNELS*CH_W  row below
- dout  out  CHANNELS*CH_W  result pixel
- valid_out  out  1  dout qualifier, single-cycle pulse per result
- eol_out  out  1  high with valid_out on the last result of each row

Interface: one clock (clk); reset (rst) is synchronous and active-high.

Behaviour:
- Reset: on clk with rst high, clear all outputs, taps, col counter, flush flag and latched mode to 0. Reset mid-row discards the partial row; the next accepted pixel is column 0.
- Column counter col: width $clog2(PIC_WIDTH).
  - Increments on each accepted pixel.
  - Wraps to 0 after PIC_WIDTH-1.
  - Holds while valid_in is low. Gaps are allowed anywhere in a row.
- Taps: per row, two column registers, prev (column c-1) and cur (column c); the incoming din is column c+1. On accept: prev <= cur, cur <= din.
- Mode latch: mode_in and se_sq_in are captured on the accept of column 0. The captured values govern the entire row, including the flush. Changes mid-row are ignored.
- Emission, normal column c = 0..PIC_WIDTH-2:
  - Occurs on the edge that accepts column c+1.
  - dout <= f(L, C, R) with L = prev (or cur if c == 0, left replicate), C = cur, R = din.
  - valid_out = 1 for that cycle. Accepting column 0 emits nothing.
- Emission, last column (c = PIC_WIDTH-1):
  - The accept of the last column sets flush.
  - On the next edge, unconditionally: dout <= f(prev, cur, cur) (right replicate), valid_out = 1, eol_out = 1, flush cleared.
  - If valid_in is high on that same edge, column 0 of the next row is accepted in parallel. The taps shift after f reads them, so there is no conflict and no stall.
- f, computed per channel independently:
  - Cross window: rows 1 and 3 at C only, plus row 2 at L, C, R.
  - Square window: all 9 taps.
  - Dilate takes the unsigned max; erode takes the unsigned min. Ties are irrelevant because the result is a value.
- Latency: 1 clk from the accept of the right-neighbour pixel to dout; 1 clk after the last-column accept for the flush result.
- Ordering: exactly PIC_WIDTH results per row, in column order.
- Outputs: dout holds its value when valid_out is low. valid_out and eol_out are otherwise 0.
- No backpressure: the downstream stage must accept every valid_out pulse.

Optional Feature:
- Macro: MORPH_BINARIZE_EN.
- Defined: each output channel is all-ones if the morphology result is >= THRESH, else 0. The compare is registered within the same stage, so latency is unchanged.
- Undefined: raw max/min values are output, and THRESH is unused.

Test Plan:
- Square dilate, CHANNELS = 1, PIC_WIDTH = 4. Rows din1 = {1,2,3,4}, din2 = {5,6,7,8}, din3 = {9,10,11,12}, continuous valid -> dout sequence 10,11,12,12. eol_out only on the 4th result, 1 clk after the last accept.
- Cross erode with the same data -> dout 1,2,3,4. Then replace din2 with {0,6,7,8} -> dout 0,0,3,4 (left replicate on column 0).
- Multi-channel independence, CHANNELS = 3. Channel 0 constant 0x10, channel 1 ramp, channel 2 constant 0xFF, dilate -> channel 0 = 0x10 and channel 2 = 0xFF on every output; channel 1 follows the max.
- valid_in gaps of 0-3 random idle cycles inside a row -> identical dout sequence to the gap-free case. Flush result appears 1 clk after the last accept, even when valid_in is low.
- Back-to-back rows, with column 0 of row 2 on the flush cycle. Toggle mode_in mid-row 1 -> row-1 results all keep row-1 mode. Exactly 2*PIC_WIDTH valid_out pulses.
- Assert rst at column 2 of a row -> valid_out = 0 and dout = 0 on the next edge. The next row starts at column 0 with a left replicate, and no stale flush result is emitted.
